// File: rtl/bbqm_teller_scheduler_if.sv
// rtl/bbqm_teller_scheduler_if.sv - call/announce handshake between scheduler and announcer
interface bbqm_teller_scheduler_if #(
    parameter int TICKET_W = 8
);
    logic                call_valid;
    logic [1:0]          call_teller;
    logic [TICKET_W-1:0] call_ticket;
    logic                call_ack;

    modport master (output call_valid, output call_teller, output call_ticket, input call_ack);
    modport slave  (input call_valid, input call_teller, input call_ticket, output call_ack);
endinterface

// File: rtl/bbqm_teller_scheduler.sv
// rtl/bbqm_teller_scheduler.sv - bank queue to teller round-robin call scheduler
// Optional BBQM_SERVICE_TIMEOUT_EN adds per-teller service timeout (svc_timeout_o).
module bbqm_teller_scheduler #(
    parameter int NUM_TELLERS = 3,
    parameter int QDEPTH      = 7,
    parameter int CNT_W       = 4,
    parameter int TICKET_W    = 8,
    parameter int CALL_TICKS  = 3
`ifdef BBQM_SERVICE_TIMEOUT_EN
    ,
    parameter int SERVICE_MAX = 15
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tick_i,
    input  logic                   arrive_i,
    input  logic [NUM_TELLERS-1:0] teller_open_i,
    input  logic [NUM_TELLERS-1:0] teller_done_i,
    output logic [CNT_W-1:0]       pcount_o,
    output logic [1:0]             tcount_o,
    output logic [NUM_TELLERS-1:0] teller_busy_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic                   overflow_o,
`ifdef BBQM_SERVICE_TIMEOUT_EN
    output logic [NUM_TELLERS-1:0] svc_timeout_o,
`endif
    bbqm_teller_scheduler_if.master call_if
);
    localparam int HOLD_W = $clog2(CALL_TICKS + 1);

    typedef enum logic {S_IDLE, S_CALL} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       pcount_q, pcount_d;
    logic [NUM_TELLERS-1:0] busy_q, busy_d;
    logic [1:0]             rr_ptr_q, rr_ptr_d;
    logic [1:0]             call_teller_q, call_teller_d;
    logic [TICKET_W-1:0]    call_ticket_q, call_ticket_d;
    logic [TICKET_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic                   overflow_q, overflow_d;

    logic [NUM_TELLERS-1:0] eligible, svc_to;
    logic                   sel_found, dispatch, accept;
    logic [1:0]             sel_idx;

    assign eligible = teller_open_i & ~busy_q;
    assign dispatch = (state_q == S_IDLE) && (pcount_q != '0) && sel_found;
    assign accept   = arrive_i && ((pcount_q < CNT_W'(QDEPTH)) || dispatch);

    // First eligible teller at or after rr_ptr, wrapping around
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 0; k < NUM_TELLERS; k++) begin
            int idx;
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_TELLERS) idx = idx - NUM_TELLERS;
            if (!sel_found && eligible[idx]) begin
                sel_found = 1'b1;
                sel_idx   = 2'(idx);
            end
        end
    end

    always_comb begin
        int n;
        n = 0;
        for (int i = 0; i < NUM_TELLERS; i++) n = n + int'(teller_open_i[i]);
        tcount_o = (n > 3) ? 2'd3 : 2'(n);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (dispatch) state_d = S_CALL;
            S_CALL: if (call_if.call_ack || (tick_i && hold_q == HOLD_W'(1))) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        call_if.call_valid  = (state_q == S_CALL);
        call_if.call_teller = call_teller_q;
        call_if.call_ticket = call_ticket_q;
    end

    always_comb begin
        pcount_d      = pcount_q + CNT_W'(accept) - CNT_W'(dispatch);
        tail_d        = accept ? tail_q + 1'b1 : tail_q;
        overflow_d    = overflow_q | (arrive_i & ~accept);
        busy_d        = busy_q & ~teller_done_i & ~svc_to;
        head_d        = head_q;
        rr_ptr_d      = rr_ptr_q;
        call_teller_d = call_teller_q;
        call_ticket_d = call_ticket_q;
        hold_d        = hold_q;
        if (dispatch) begin
            busy_d[sel_idx] = 1'b1;
            call_teller_d   = sel_idx;
            call_ticket_d   = head_q;
            head_d          = head_q + 1'b1;
            rr_ptr_d        = (int'(sel_idx) == NUM_TELLERS - 1) ? 2'd0 : sel_idx + 2'd1;
            hold_d          = HOLD_W'(CALL_TICKS);
        end else if (state_q == S_CALL && tick_i && hold_q != '0) begin
            hold_d = hold_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcount_q      <= '0;
            busy_q        <= '0;
            rr_ptr_q      <= '0;
            call_teller_q <= '0;
            call_ticket_q <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            hold_q        <= '0;
            overflow_q    <= 1'b0;
        end else begin
            pcount_q      <= pcount_d;
            busy_q        <= busy_d;
            rr_ptr_q      <= rr_ptr_d;
            call_teller_q <= call_teller_d;
            call_ticket_q <= call_ticket_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            hold_q        <= hold_d;
            overflow_q    <= overflow_d;
        end
    end

`ifdef BBQM_SERVICE_TIMEOUT_EN
    localparam int SVC_W = $clog2(SERVICE_MAX + 1);

    logic [SVC_W-1:0]       svc_cnt_q [NUM_TELLERS];
    logic [SVC_W-1:0]       svc_cnt_d [NUM_TELLERS];
    logic [NUM_TELLERS-1:0] svc_pulse_q;

    // A done arriving with the expiring tick wins, so no timeout pulse
    always_comb begin
        for (int i = 0; i < NUM_TELLERS; i++) begin
            svc_cnt_d[i] = svc_cnt_q[i];
            svc_to[i]    = 1'b0;
            if (busy_q[i] && tick_i) begin
                if (svc_cnt_q[i] == SVC_W'(SERVICE_MAX - 1)) begin
                    svc_to[i]    = ~teller_done_i[i];
                    svc_cnt_d[i] = '0;
                end else begin
                    svc_cnt_d[i] = svc_cnt_q[i] + 1'b1;
                end
            end
            if (dispatch && int'(sel_idx) == i) svc_cnt_d[i] = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_TELLERS; i++) svc_cnt_q[i] <= '0;
            svc_pulse_q <= '0;
        end else begin
            for (int i = 0; i < NUM_TELLERS; i++) svc_cnt_q[i] <= svc_cnt_d[i];
            svc_pulse_q <= svc_to;
        end
    end

    assign svc_timeout_o = svc_pulse_q;
`else
    assign svc_to = '0;
`endif

    assign pcount_o      = pcount_q;
    assign teller_busy_o = busy_q;
    assign full_o        = (pcount_q == CNT_W'(QDEPTH));
    assign empty_o       = (pcount_q == '0);
    assign overflow_o    = overflow_q;
endmodule

// File: tb/tb_bbqm_teller_scheduler.sv
// tb/tb_bbqm_teller_scheduler.sv - directed self-checking bench for bbqm_teller_scheduler
module tb_bbqm_teller_scheduler;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       arrive = 1'b0;
    logic [2:0] topen = 3'b000;
    logic [2:0] tdone = 3'b000;
    logic [3:0] pcount;
    logic [1:0] tcount;
    logic [2:0] busy;
    logic       full, empty, overflow;
`ifdef BBQM_SERVICE_TIMEOUT_EN
    logic [2:0] svc_timeout;
`endif
    int n_cmp = 0;
    int n_bad = 0;

    bbqm_teller_scheduler_if #(.TICKET_W(8)) call_if ();

    bbqm_teller_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .tick_i        (tick),
        .arrive_i      (arrive),
        .teller_open_i (topen),
        .teller_done_i (tdone),
        .pcount_o      (pcount),
        .tcount_o      (tcount),
        .teller_busy_o (busy),
        .full_o        (full),
        .empty_o       (empty),
        .overflow_o    (overflow),
`ifdef BBQM_SERVICE_TIMEOUT_EN
        .svc_timeout_o (svc_timeout),
`endif
        .call_if       (call_if)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        call_if.call_ack = 1'b0;
        step();
        check_eq("rst_pcount", pcount, 0);
        check_eq("rst_empty", empty, 1);
        check_eq("rst_full", full, 0);
        check_eq("rst_valid", call_if.call_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ovf", overflow, 0);
        reset = 1'b0;

        arrive = 1'b1;
        repeat (3) step();
        arrive = 1'b0;
        check_eq("q3_pcount", pcount, 3);
        check_eq("q3_empty", empty, 0);
        check_eq("q3_tcount", tcount, 0);
        check_eq("q3_valid", call_if.call_valid, 0);

        topen = 3'b111;
        #1;
        check_eq("tcount3", tcount, 3);
        step();
        check_eq("c0_valid", call_if.call_valid, 1);
        check_eq("c0_teller", call_if.call_teller, 0);
        check_eq("c0_ticket", call_if.call_ticket, 0);
        check_eq("c0_pcount", pcount, 2);
        for (int i = 1; i < 3; i++) begin
            call_if.call_ack = 1'b1;
            step();
            call_if.call_ack = 1'b0;
            check_eq("ack_valid", call_if.call_valid, 0);
            step();
            check_eq("cn_valid", call_if.call_valid, 1);
            check_eq("cn_teller", call_if.call_teller, i);
            check_eq("cn_ticket", call_if.call_ticket, i);
            check_eq("cn_pcount", pcount, 2 - i);
        end
        call_if.call_ack = 1'b1;
        step();
        call_if.call_ack = 1'b0;
        step();
        check_eq("drain_valid", call_if.call_valid, 0);
        check_eq("drain_busy", busy, 3'b111);
        check_eq("drain_empty", empty, 1);

        tdone = 3'b001;
        arrive = 1'b1;
        step();
        tdone = 3'b000;
        arrive = 1'b0;
        check_eq("d0_busy", busy, 3'b110);
        check_eq("d0_pcount", pcount, 1);
        step();
        check_eq("c3_teller", call_if.call_teller, 0);
        check_eq("c3_ticket", call_if.call_ticket, 3);
        for (int t = 0; t < 2; t++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            check_eq("hold_valid", call_if.call_valid, 1);
        end
        step();
        step();
        check_eq("hold_idle_valid", call_if.call_valid, 1);
        tick = 1'b1;
        step();
        tick = 1'b0;
        check_eq("tick3_drop", call_if.call_valid, 0);

        arrive = 1'b1;
        repeat (2) step();
        arrive = 1'b0;
        check_eq("q2_pcount", pcount, 2);
        tdone = 3'b010;
        step();
        tdone = 3'b000;
        check_eq("d1_busy", busy, 3'b101);
        step();
        check_eq("c4_teller", call_if.call_teller, 1);
        check_eq("c4_ticket", call_if.call_ticket, 4);
        check_eq("c4_pcount", pcount, 1);
        check_eq("c4_busy", busy, 3'b111);

        topen = 3'b000;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("rst2_pcount", pcount, 0);
        arrive = 1'b1;
        repeat (8) step();
        arrive = 1'b0;
        check_eq("ovf_pcount", pcount, 7);
        check_eq("ovf_full", full, 1);
        check_eq("ovf_flag", overflow, 1);
        topen = 3'b001;
        arrive = 1'b1;
        step();
        arrive = 1'b0;
        check_eq("fd_valid", call_if.call_valid, 1);
        check_eq("fd_ticket", call_if.call_ticket, 0);
        check_eq("fd_pcount", pcount, 7);
        for (int i = 1; i <= 7; i++) begin
            call_if.call_ack = 1'b1;
            tdone = 3'b001;
            step();
            call_if.call_ack = 1'b0;
            tdone = 3'b000;
            step();
            check_eq("dr_ticket", call_if.call_ticket, i);
            check_eq("dr_pcount", pcount, 7 - i);
        end
        check_eq("dr_ovf", overflow, 1);

        arrive = 1'b1;
        repeat (4) step();
        arrive = 1'b0;
        check_eq("pr_valid", call_if.call_valid, 1);
        check_eq("pr_pcount", pcount, 4);
        #2;
        reset = 1'b1;
        #1;
        check_eq("ar_pcount", pcount, 0);
        check_eq("ar_valid", call_if.call_valid, 0);
        check_eq("ar_busy", busy, 0);
        check_eq("ar_ovf", overflow, 0);
        check_eq("ar_ticket", call_if.call_ticket, 0);
        check_eq("ar_teller", call_if.call_teller, 0);
        step();
        reset = 1'b0;

`ifdef BBQM_SERVICE_TIMEOUT_EN
        arrive = 1'b1;
        step();
        arrive = 1'b0;
        step();
        call_if.call_ack = 1'b1;
        step();
        call_if.call_ack = 1'b0;
        check_eq("to_busy0", busy, 3'b001);
        repeat (14) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
        end
        check_eq("to_busy14", busy, 3'b001);
        check_eq("to_svc14", svc_timeout, 0);
        tick = 1'b1;
        step();
        tick = 1'b0;
        check_eq("to_busy15", busy, 3'b000);
        check_eq("to_svc15", svc_timeout, 3'b001);
        step();
        check_eq("to_svc_end", svc_timeout, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bbqm_teller_scheduler.md
Name: bbqm_teller_scheduler

Overview:
Controller that sequences customers from the bank queue to tellers. It tracks queue occupancy and per-teller busy state, and calls the head-of-queue ticket to a free open teller using round-robin selection. It feeds the occupancy counter display, the 2-bit open-teller count used by the wait-time lookup, and the call/announce display. It sits between the synchronized push-button inputs and the display/wait-time datapath.

Parameters:
NUM_TELLERS, 3, number of teller stations (1..3)
QDEPTH, 7, maximum queued customers
CNT_W, 4, width of pcount
TICKET_W, 8, ticket number width, wraps modulo 2^TICKET_W
CALL_TICKS, 3, call display hold time in tick periods (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
tick  in  1  one-clk-wide enable from clock divider (slow time base)
arrive  in  1  one-clk pulse, customer joins queue (pre-synchronized)
teller_open  in  NUM_TELLERS  level, teller station staffed
teller_done  in  NUM_TELLERS  one-clk pulse, teller finished service
call_ack  in  1  announcer acknowledges current call
pcount  out  CNT_W  customers waiting
tcount  out  2  number of open tellers, saturating at 3
teller_busy  out  NUM_TELLERS  teller serving a customer
call_valid  out  1  call being announced
call_teller  out  2  index of called teller
call_ticket  out  TICKET_W  ticket being called
full  out  1  pcount == QDEPTH
empty  out  1  pcount == 0
overflow  out  1  sticky, an arrival was dropped

Behaviour:
- Reset (asynchronous) values: pcount=0, teller_busy=0, call_valid=0, call_teller=0, call_ticket=0, overflow=0, tail_ticket=0, head_ticket=0, rr_ptr=0, FSM=IDLE. Reset applies mid-call or mid-service and clears everything. full/empty/tcount are combinational from registers/inputs.
- Arrival: if pcount<QDEPTH, pcount+1 and tail_ticket+1. Otherwise the customer is dropped and overflow is set; overflow stays set until reset.
- Arrival together with dispatch in the same cycle: net pcount unchanged. An arrival at full is accepted when a dispatch occurs in the same cycle.
- Eligible teller: teller_open[i] & ~teller_busy[i].
- FSM IDLE: if pcount>0 and any teller is eligible, dispatch on that clk edge:
  - select the first eligible teller scanning from rr_ptr upward, with wrap;
  - set teller_busy[sel]; pcount-1;
  - call_teller=sel, call_ticket=head_ticket, head_ticket+1;
  - rr_ptr=(sel+1) mod NUM_TELLERS; hold=CALL_TICKS; call_valid=1; go to CALL.
  - call_valid is therefore asserted 1 clk after the eligibility condition becomes true.
- FSM CALL: call_valid, call_teller and call_ticket are held stable.
  - Each tick decrements hold.
  - On call_ack, or on a tick with hold==1: call_valid=0 and return to IDLE.
  - No new dispatch while in CALL. Back-to-back calls are separated by at least one IDLE cycle.
- teller_done[i]: clears teller_busy[i] if set; ignored if not busy. A teller freed by done becomes eligible the next cycle.
- Closing a busy teller (teller_open falls) does not clear busy. Closed tellers are never selected.
- tcount = popcount(teller_open), saturated to 3.
- Ticket arithmetic wraps modulo 2^TICKET_W. head_ticket never passes tail_ticket.

Optional Feature:
BBQM_SERVICE_TIMEOUT_EN
- Defined: adds parameter SERVICE_MAX (default 15 ticks) and output svc_timeout [NUM_TELLERS].
  - Each busy teller has a tick counter, cleared when the teller is dispatched.
  - When the counter reaches SERVICE_MAX, teller_busy is cleared and svc_timeout[i] pulses for 1 clk.
  - teller_done in the same cycle as timeout: done takes priority; no pulse.
- Undefined: no timers; busy is held until teller_done; svc_timeout port absent.

Test Plan:
- Reset then 3 arrive pulses, all teller_open=0 -> pcount=3, empty=0, tcount=0, call_valid stays 0.
- teller_open=3'b111, queue 3 -> call teller0 ticket0; after call_ack, teller1 ticket1, then teller2 ticket2; pcount reaches 0; teller_busy=3'b111; empty=1.
- 8 arrive pulses, no tellers open -> pcount=7, full=1, overflow=1. Then arrive together with dispatch at full -> pcount stays 7, tail_ticket advances.
- CALL_TICKS=3, no call_ack -> call_valid drops on the 3rd tick after dispatch.
- teller_done[1] while teller1 is busy and the queue is non-empty -> busy[1] clears; next call names teller1 with the next head ticket.
- Assert reset during CALL with pcount=4 -> all outputs return to reset values immediately; with BBQM_SERVICE_TIMEOUT_EN, an unserviced teller times out after 15 ticks and svc_timeout pulses once.
